// File: rtl/passthru_8b_rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// passthru_8b_rr_arb_pkg
//
// Shared definitions for the two-requester round-robin pass-through buffer:
//   - NBITS_DEFAULT : default message width (8 bits)
//   - buf_state_e   : output buffer state (EMPTY / FULL)
//   - rr_grant()    : one-hot grant for two requesters given the priority
//                     pointer (pointer names the requester favoured on a tie)
// -----------------------------------------------------------------------------
package passthru_8b_rr_arb_pkg;

    localparam int NBITS_DEFAULT = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // A lone requester always wins; on a tie the pointer decides.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic ptr);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage : passthru_8b_rr_arb_pkg

// File: rtl/rr_arb_2.sv
// -----------------------------------------------------------------------------
// rr_arb_2
//
// Two-requester round-robin arbiter: combinational one-hot grant plus the
// priority pointer register.
//
// Ports:
//   clk_i    : clock, rising-edge
//   reset_ni : asynchronous active-low reset (pointer returns to 0)
//   req_i    : request vector, bit X = requester X wants service
//   en_i     : a granted request was actually served this cycle
//   gnt_o    : one-hot grant (all zero when nobody requests)
//   ptr_o    : current priority pointer (debug visibility)
// -----------------------------------------------------------------------------
module rr_arb_2
    import passthru_8b_rr_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    assign gnt_o = rr_grant(req_i, ptr_q);
    assign ptr_o = ptr_q;

    // After serving requester X the other one gets priority. The pointer
    // only moves when a grant turns into a real transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb_2

// File: rtl/passthru_8b_rr_arb.sv
// -----------------------------------------------------------------------------
// passthru_8b_rr_arb
//
// Two requesters share one registered output slot through a round-robin
// arbiter. Messages pass through unmodified with one cycle of latency and
// full throughput (drain and refill in the same cycle).
//
// Handshake: every port uses valid/ready. A transfer happens exactly at a
// rising edge where val and rdy are both 1. A requester may not make val
// depend on rdy; rdy here depends only on the vals, out_rdy and internal
// state, never on message data.
//
// Ports:
//   clk            : clock, rising-edge
//   reset          : asynchronous active-low reset
//   in0_val/rdy/msg: requester 0 channel
//   in1_val/rdy/msg: requester 1 channel
//   out_val/rdy    : output channel handshake
//   out_msg        : registered message
//   out_src        : index of the requester that produced out_msg
//   dbg_state_o    : buffer FSM state (debug)
//   dbg_ptr_o      : arbiter priority pointer (debug)
// -----------------------------------------------------------------------------
module passthru_8b_rr_arb
    import passthru_8b_rr_arb_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [NBITS-1:0] in0_msg,
    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [NBITS-1:0] in1_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             out_src,
    output buf_state_e       dbg_state_o,
    output logic             dbg_ptr_o
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [NBITS-1:0] msg_q;
    logic [NBITS-1:0] msg_d;
    logic             src_q;
    logic             src_d;

    logic [1:0]       gnt;
    logic             can_accept;
    logic             xfer;
    logic [NBITS-1:0] sel_msg;

    rr_arb_2 u_arb (
        .clk_i    (clk),
        .reset_ni (reset),
        .req_i    ({in1_val, in0_val}),
        .en_i     (xfer),
        .gnt_o    (gnt),
        .ptr_o    (dbg_ptr_o)
    );

    // The slot can take a new message when empty, or when full and the
    // consumer drains it in the same cycle.
    assign can_accept = (state_q == EMPTY) || out_rdy;

    // Gating with reset keeps both rdys low for the whole reset window,
    // even though the buffer already reads EMPTY then.
    assign in0_rdy = reset & can_accept & gnt[0];
    assign in1_rdy = reset & can_accept & gnt[1];

    assign xfer    = (in0_val & in0_rdy) | (in1_val & in1_rdy);
    assign sel_msg = gnt[1] ? in1_msg : in0_msg;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        src_d   = src_q;
        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                    msg_d   = sel_msg;
                    src_d   = gnt[1];
                end
            end
            FULL: begin
                if (out_rdy) begin
                    if (xfer) begin
                        state_d = FULL;
                        msg_d   = sel_msg;
                        src_d   = gnt[1];
                    end else begin
                        // Drained: payload registers keep their last value.
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            msg_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            src_q   <= src_d;
        end
    end

    assign out_val     = (state_q == FULL);
    assign out_msg     = msg_q;
    assign out_src     = src_q;
    assign dbg_state_o = state_q;

endmodule : passthru_8b_rr_arb

// File: tb/tb_passthru_8b_rr_arb.sv
module tb_passthru_8b_rr_arb;
    import passthru_8b_rr_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic       in0_val;
    logic       in0_rdy;
    logic [7:0] in0_msg;
    logic       in1_val;
    logic       in1_rdy;
    logic [7:0] in1_msg;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;
    logic       out_src;
    buf_state_e dbg_state;
    logic       dbg_ptr;

    passthru_8b_rr_arb #(.NBITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in0_val     (in0_val),
        .in0_rdy     (in0_rdy),
        .in0_msg     (in0_msg),
        .in1_val     (in1_val),
        .in1_rdy     (in1_rdy),
        .in1_msg     (in1_msg),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_msg     (out_msg),
        .out_src     (out_src),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    // random-phase reference model
    logic       m_full;
    logic       m_ptr;
    logic       m_xfer;
    logic       m_src;
    logic [7:0] last_msg;
    logic       last_src;
    logic       e_r0;
    logic       e_r1;
    logic       ca;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge. Drives one cycle of inputs, checks the
    // rdys mid-cycle, then checks the registered outputs after the next edge.
    task automatic step(input string tag,
                        input logic v0, input logic [7:0] m0,
                        input logic v1, input logic [7:0] m1,
                        input logic ordy,
                        input logic er0, input logic er1,
                        input logic eval, input logic [7:0] emsg, input logic esrc);
        in0_val = v0;
        in0_msg = m0;
        in1_val = v1;
        in1_msg = m1;
        out_rdy = ordy;
        @(negedge clk);
        chk({tag, ".in0_rdy"}, in0_rdy, er0);
        chk({tag, ".in1_rdy"}, in1_rdy, er1);
        @(posedge clk);
        #1;
        chk({tag, ".out_val"}, out_val, eval);
        chk({tag, ".out_msg"}, out_msg, emsg);
        chk({tag, ".out_src"}, out_src, esrc);
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset   = 1'b0;
        in0_val = 1'b1;
        in0_msg = 8'h5A;
        in1_val = 1'b0;
        in1_msg = 8'h00;
        out_rdy = 1'b1;
        #3;
        chk("rst.out_val", out_val, 1'b0);
        chk("rst.out_msg", out_msg, 8'h00);
        chk("rst.out_src", out_src, 1'b0);
        chk("rst.in0_rdy", in0_rdy, 1'b0);
        chk("rst.in1_rdy", in1_rdy, 1'b0);
        chk("rst.ptr", dbg_ptr, 1'b0);
        in0_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single requester 0
        step("s01", 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        // single requester 1 (pointer back to 0)
        step("s02", 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
        // both requesting every cycle: alternate 0,1,0,1
        step("s03", 1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0);
        step("s04", 1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1);
        step("s05", 1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0);
        step("s06", 1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1);
        // only requester 1 twice with pointer 0
        step("s07", 1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1);
        step("s08", 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1);
        chk("s08.ptr", dbg_ptr, 1'b0);
        // tie now goes to requester 0, proving the pointer stayed 0
        step("s09", 1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
        // stalled output: requester 1 blocked, 0x55 held
        step("s10", 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        step("s11", 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        step("s12", 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        chk("s12.state", dbg_state, FULL);
        step("s13", 1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        // drain with no input: EMPTY, payload held
        step("s14", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
        step("s15", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
        // EMPTY accepts regardless of out_rdy
        step("s16", 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);

        // ---------------- asynchronous reset mid-cycle ----------------
        in0_val = 1'b1;
        in0_msg = 8'h12;
        in1_val = 1'b0;
        out_rdy = 1'b1;
        #2;
        chk("ar.pre_in0_rdy", in0_rdy, 1'b1);
        reset = 1'b0;
        #1;
        chk("ar.out_val", out_val, 1'b0);
        chk("ar.out_msg", out_msg, 8'h00);
        chk("ar.out_src", out_src, 1'b0);
        chk("ar.in0_rdy", in0_rdy, 1'b0);
        chk("ar.in1_rdy", in1_rdy, 1'b0);
        chk("ar.state", dbg_state, EMPTY);
        @(posedge clk);
        #1;
        chk("ar.held_out_val", out_val, 1'b0);
        in0_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("s17", 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
        step("s18", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1);

        // ---------------- random traffic ----------------
        m_full   = 1'b0;
        m_ptr    = 1'b0;
        last_msg = 8'h3C;
        last_src = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in0_val = 1'($urandom_range(0, 1));
            in1_val = 1'($urandom_range(0, 1));
            in0_msg = 8'($urandom_range(0, 255));
            in1_msg = 8'($urandom_range(0, 255));
            out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            ca   = !m_full || out_rdy;
            e_r0 = ca && in0_val && (!in1_val || !m_ptr);
            e_r1 = ca && in1_val && (!in0_val || m_ptr);
            chk($sformatf("rnd%0d.in0_rdy", i), in0_rdy, e_r0);
            chk($sformatf("rnd%0d.in1_rdy", i), in1_rdy, e_r1);
            chk($sformatf("rnd%0d.one_hot", i), in0_rdy & in1_rdy, 1'b0);
            m_xfer = e_r0 || e_r1;
            m_src  = e_r1;
            if (e_r0) exp_q0.push_back(in0_msg);
            if (e_r1) exp_q1.push_back(in1_msg);
            if (m_xfer) begin
                m_full = 1'b1;
                m_ptr  = !m_src;
            end else if (out_rdy) begin
                m_full = 1'b0;
            end
            @(posedge clk);
            #1;
            if (m_xfer) begin
                last_src = m_src;
                if (m_src) last_msg = exp_q1.pop_front();
                else       last_msg = exp_q0.pop_front();
            end
            chk($sformatf("rnd%0d.out_val", i), out_val, m_full);
            chk($sformatf("rnd%0d.out_msg", i), out_msg, last_msg);
            chk($sformatf("rnd%0d.out_src", i), out_src, last_src);
        end
        chk("rnd.q0_empty", exp_q0.size(), 0);
        chk("rnd.q1_empty", exp_q1.size(), 0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_passthru_8b_rr_arb

// File: doc/passthru_8b_rr_arb.md
PASSTHRU_8B_RR_ARB -- requirements
Module: passthru_8b_rr_arb

Interface
REQ-001 Parameter: NBITS, default 8, message width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 Port: in0_val  input  1  requester 0 offers a message.
REQ-005 Port: in0_rdy  output  1  block accepts requester 0's message this cycle.
REQ-006 Port: in0_msg  input  NBITS  requester 0 message.
REQ-007 Port: in1_val  input  1  requester 1 offers a message.
REQ-008 Port: in1_rdy  output  1  block accepts requester 1's message this cycle.
REQ-009 Port: in1_msg  input  NBITS  requester 1 message.
REQ-010 Port: out_val  output  1  out_msg holds a valid message.
REQ-011 Port: out_rdy  input  1  consumer accepts the output message this cycle.
REQ-012 Port: out_msg  output  NBITS  registered message passed through unmodified.
REQ-013 Port: out_src  output  1  requester index (0/1) that produced out_msg.

Function
REQ-014 Transfer on any port SHALL occur exactly in a cycle where its val and rdy are both 1 at the rising edge.
REQ-015 Buffer state machine SHALL have two states: EMPTY (out_val=0) and FULL (out_val=1).
REQ-016 can_accept SHALL equal (state==EMPTY) or (state==FULL and out_rdy==1).
REQ-017 Grant: only in0_val=1 -> requester 0; only in1_val=1 -> requester 1; both -> requester named by priority pointer; neither -> no grant.
REQ-018 inX_rdy SHALL be 1 only when can_accept=1 and requester X holds the grant; at most one of in0_rdy/in1_rdy SHALL be 1 in any cycle.
REQ-019 inX_rdy SHALL depend combinationally only on in0_val, in1_val, out_rdy and internal state, never on message data.
REQ-020 On an input transfer from X, next cycle out_msg SHALL equal inX_msg bit-exact, out_src=X, state=FULL (latency exactly one cycle).
REQ-021 In FULL with out_rdy=1 and no input transfer, next state SHALL be EMPTY; out_msg/out_src SHALL hold their last values.
REQ-022 In FULL with out_rdy=0, out_msg, out_src and state SHALL be held unchanged regardless of inputs.
REQ-023 Simultaneous output drain and input transfer SHALL keep state FULL and load the new message (full throughput, one message per cycle).
REQ-024 Priority pointer SHALL update only on an input transfer, to the index not just served; otherwise it SHALL hold.
REQ-025 No message SHALL be dropped, duplicated or reordered per requester.

Reset
REQ-026 While reset=0, state=EMPTY, out_val=0, out_msg=0, out_src=0, priority pointer=0, in0_rdy=in1_rdy=0, taking effect immediately without a clock edge.
REQ-027 Reset asserted mid-operation SHALL discard any buffered message; first transfer is possible in the first rising edge after reset returns to 1.

Structure
REQ-028 A shared package SHALL hold the buffer state enumeration (EMPTY, FULL) and the default NBITS constant (8).
REQ-029 Grant logic plus priority pointer register SHALL be a sub-module named rr_arb_2 (inputs: two requests, update enable; outputs: one-hot grant).
REQ-030 out_msg, out_src, state and pointer SHALL be flip-flops; no latches.

Verification
REQ-031 Reset then in0_val=1, in0_msg=0x01, out_rdy=1 -> in0_rdy=1; next cycle out_val=1, out_msg=0x01, out_src=0.
REQ-032 Both val every cycle, in0_msg=0xA0, in1_msg=0xB1, out_rdy=1 -> grants alternate 0,1,0,1; out_msg sequence 0xA0,0xB1,0xA0,0xB1 with out_val held at 1.
REQ-033 Out FULL with 0x55, out_rdy=0 for 3 cycles, in1_val=1 with 0x77 -> in1_rdy=0, out_msg stays 0x55; out_rdy=1 -> in1 transfers, next cycle out_msg=0x77, out_src=1.
REQ-034 Only in1_val=1 (0x80, 0x08) for two cycles with pointer=0 -> requester 1 served both cycles; pointer ends at 0.
REQ-035 Out FULL with 0xFF, reset=0 asynchronously mid-cycle -> out_val, out_msg, out_rdy-driven rdys drop to 0 before next edge; after release, first output follows new input only.
REQ-036 20 random cycles of random vals/msgs/out_rdy -> scoreboard per-requester order and values match; at most one rdy high per cycle.
